// File: rtl/pfu_pipe_if.sv
// Prefetch-unit bundle: ibus request/response channel, decoder-side instruction stream and
// execute-stage vector/privilege inputs. master = prefetch unit, slave = environment.
interface pfu_pipe_if;
    logic        ireqready;
    logic        ireqvalid;
    logic [1:0]  ireqhpl;
    logic [31:0] ireqaddr;
    logic        irspvalid;
    logic        irsprerr;
    logic [31:0] irspdata;
    logic        irspready;
    logic        ids_dav;
    logic        ids_ack;
    logic [1:0]  ids_ack_size;
    logic        ids_sofid;
    logic [31:0] ids_ins;
    logic        ids_ferr;
    logic [31:0] ids_pc;
    logic        exs_pc_wr;
    logic [31:0] exs_pc_din;
    logic [1:0]  exs_hpl;

    modport master (
        input  ireqready,
        output ireqvalid,
        output ireqhpl,
        output ireqaddr,
        input  irspvalid,
        input  irsprerr,
        input  irspdata,
        output irspready,
        output ids_dav,
        input  ids_ack,
        input  ids_ack_size,
        output ids_sofid,
        output ids_ins,
        output ids_ferr,
        output ids_pc,
        input  exs_pc_wr,
        input  exs_pc_din,
        input  exs_hpl
    );

    modport slave (
        output ireqready,
        input  ireqvalid,
        input  ireqhpl,
        input  ireqaddr,
        output irspvalid,
        output irsprerr,
        output irspdata,
        input  irspready,
        input  ids_dav,
        output ids_ack,
        output ids_ack_size,
        input  ids_sofid,
        input  ids_ins,
        input  ids_ferr,
        input  ids_pc,
        output exs_pc_wr,
        output exs_pc_din,
        output exs_hpl
    );
endinterface

// File: rtl/pfu_pipe.sv
// Instruction prefetch unit: issues word fetches on the ibus, splits responses into 16-bit atoms
// and presents whole (16- or 32-bit) instructions to the decoder.
module pfu_pipe #(
    parameter int unsigned C_FIFO_DEPTH_X    = 2,
    parameter int unsigned C_MAX_OUTSTANDING = 2,
    parameter logic [31:0] C_RESET_VECTOR    = 32'h0
) (
    input  logic       clk_i,
    input  logic       resetb_i,
    input  logic       clk_en_i,
    pfu_pipe_if.master bus
);
    localparam int unsigned PtrW    = C_FIFO_DEPTH_X + 1;
    localparam int unsigned Depth   = 2 ** PtrW;
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned SumW    = CntW + 3;
    localparam int unsigned LineCap = 2 ** C_FIFO_DEPTH_X;

    typedef struct packed {
        logic [15:0] data;
        logic [30:0] pc;
        logic        ferr;
        logic        sof;
    } atom_t;

    atom_t           mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [2:0]      outst_q, outst_d;
    logic [2:0]      disc_q, disc_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:2]     rpc_q, rpc_d;
    logic            sof_pend_q, sof_pend_d;
    logic            skip_q, skip_d;

    logic [SumW-1:0] occ_lines, inflight;
    logic            req_ok, req_hs, rsp, keep, skip, vec, pop_en;
    logic            we0, we1;
    logic [1:0]      push_n, pop_n;
    atom_t           head, nxt, atom0, atom1, wdata0, wdata1;
    logic            is_c, dav;
    logic            unused_bits;

    // Occupancy is counted in whole lines so every in-flight response is guaranteed room.
    always_comb begin
        occ_lines = (SumW'(count_q) + SumW'(1)) >> 1;
        inflight  = SumW'(outst_q) + occ_lines;
        req_ok    = clk_en_i && !bus.exs_pc_wr
                    && (outst_q < 3'(C_MAX_OUTSTANDING))
                    && (inflight < SumW'(LineCap));
    end

    assign bus.ireqvalid = req_ok;
    assign bus.ireqaddr  = {pc_q[31:2], 2'b00};
    assign bus.ireqhpl   = bus.exs_hpl;
    assign bus.irspready = 1'b1;

    assign head = mem_q[rd_ptr_q];
    assign nxt  = mem_q[rd_ptr_q + PtrW'(1)];
    assign is_c = (head.data[1:0] != 2'b11);
    assign dav  = ((count_q >= CntW'(1)) && is_c) || (count_q >= CntW'(2));

    always_comb begin
        bus.ids_dav   = dav;
        bus.ids_ins   = '0;
        bus.ids_pc    = '0;
        bus.ids_sofid = 1'b0;
        bus.ids_ferr  = 1'b0;
        if (dav) begin
            bus.ids_ins   = is_c ? {16'h0, head.data} : {nxt.data, head.data};
            bus.ids_pc    = {head.pc, 1'b0};
            bus.ids_sofid = head.sof;
            bus.ids_ferr  = head.ferr | (!is_c & nxt.ferr);
        end
    end

    assign unused_bits = ^{bus.ids_ack_size[0], nxt.pc, nxt.sof, pc_q[1:0]};

    always_comb begin
        vec    = clk_en_i && bus.exs_pc_wr;
        rsp    = clk_en_i && bus.irspvalid;
        req_hs = req_ok && bus.ireqready;
        keep   = rsp && !vec && (disc_q == 3'd0);
        skip   = sof_pend_q && skip_q;
        pop_en = clk_en_i && bus.ids_ack && dav && !vec;

        // A 2-atom ack is clamped to what is actually held so the pointers never cross.
        pop_n = 2'd0;
        if (pop_en) begin
            pop_n = (bus.ids_ack_size[1] && (count_q >= CntW'(2))) ? 2'd2 : 2'd1;
        end
        push_n = !keep ? 2'd0 : (skip ? 2'd1 : 2'd2);

        atom0.data = bus.irspdata[15:0];
        atom0.pc   = {rpc_q, 1'b0};
        atom0.ferr = bus.irsprerr;
        atom0.sof  = sof_pend_q;
        atom1.data = bus.irspdata[31:16];
        atom1.pc   = {rpc_q, 1'b1};
        atom1.ferr = bus.irsprerr;
        atom1.sof  = skip;
        wdata0     = skip ? atom1 : atom0;
        wdata1     = atom1;
        we0        = keep;
        we1        = keep && !skip;

        pc_d       = pc_q;
        rpc_d      = rpc_q;
        sof_pend_d = sof_pend_q;
        skip_d     = skip_q;
        outst_d    = outst_q;
        disc_d     = disc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (vec) begin
            pc_d       = bus.exs_pc_din;
            rpc_d      = bus.exs_pc_din[31:2];
            sof_pend_d = 1'b1;
            skip_d     = bus.exs_pc_din[1];
            outst_d    = outst_q - 3'(rsp);
            disc_d     = outst_q - 3'(rsp);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req_hs) begin
                pc_d = pc_q + 32'd4;
            end
            outst_d = outst_q + 3'(req_hs) - 3'(rsp);
            if (rsp && (disc_q != 3'd0)) begin
                disc_d = disc_q - 3'd1;
            end
            if (keep) begin
                rpc_d      = rpc_q + 30'd1;
                sof_pend_d = 1'b0;
            end
            wr_ptr_d = wr_ptr_q + PtrW'(push_n);
            rd_ptr_d = rd_ptr_q + PtrW'(pop_n);
            count_d  = count_q + CntW'(push_n) - CntW'(pop_n);
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            pc_q       <= C_RESET_VECTOR;
            rpc_q      <= C_RESET_VECTOR[31:2];
            sof_pend_q <= 1'b1;
            skip_q     <= C_RESET_VECTOR[1];
            outst_q    <= '0;
            disc_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else if (clk_en_i) begin
            pc_q       <= pc_d;
            rpc_q      <= rpc_d;
            sof_pend_q <= sof_pend_d;
            skip_q     <= skip_d;
            outst_q    <= outst_d;
            disc_q     <= disc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we0) begin
            mem_q[wr_ptr_q] <= wdata0;
        end
        if (we1) begin
            mem_q[wr_ptr_q + PtrW'(1)] <= wdata1;
        end
    end
endmodule
